multicycle_ctrl_fsm: RTL and testbench

//   Multi-cycle MIPS control sequencer. Replaces single-cycle decode: steps shared ALU/memory/regfile

---
 rtl/multicycle_ctrl_fsm_if.sv | 44 ++++
 rtl/multicycle_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle MIPS sequencer and its datapath.
//   opcode/funct/mem_ready : datapath -> sequencer (IR fields, memory handshake)
//   pc_write .. illegal_op : sequencer -> datapath (selects, strobes, ALU op, debug)
// master modport: the sequencer. slave modport: the datapath.
interface multicycle_ctrl_fsm_if;
    localparam int unsigned OP_W       = 6;
    localparam int unsigned STATE_W    = 4;
    localparam int unsigned ALU_CTRL_W = 4;

    logic [OP_W-1:0]       opcode;
    logic [OP_W-1:0]       funct;
    logic                  mem_ready;

    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_source;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [STATE_W-1:0]    state;
    logic                  instr_done;
    logic                  illegal_op;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_control, state, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_control, state, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: walks one instruction at a time through
// FETCH..WRITEBACK and decodes datapath selects, strobes and ALU op from the state
// register (plus funct in R_EXEC).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; forces every output to 0 while high
//   bus  - multicycle_ctrl_fsm_if.master (opcode/funct/mem_ready in, controls out)
// Optional build macro MEM_READY_EN: FETCH, MEM_RD and MEM_WR wait for mem_ready.
module multicycle_ctrl_fsm (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_ctrl_fsm_if.master       bus
);
    localparam int unsigned STATE_W    = 4;
    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    state_t state_q;
    state_t state_next;

    // Memory-state completion: the handshake when enabled, otherwise every access is one cycle.
    logic mem_go;
`ifdef MEM_READY_EN
    assign mem_go = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign mem_go           = 1'b1;
    assign unused_mem_ready = bus.mem_ready;
`endif

    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_source;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [STATE_W-1:0]    state_dbg;
    logic                  instr_done;
    logic                  illegal_op;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_next;
    end

    // Next-state and Moore output decode
    always_comb begin
        state_next    = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_control   = ALU_AND;
        state_dbg     = STATE_W'(state_q);
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read    = 1'b1;
                // IR/PC load only in the cycle the fetch data is actually there
                ir_write    = mem_go;
                pc_write    = mem_go;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                if (mem_go) state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EXEC;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                state_next  = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_go) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                // done stays a single pulse even while the store is held waiting
                instr_done = mem_go;
                if (mem_go) state_next = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                state_next = S_R_WB;
                case (bus.funct)
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: state_next  = S_ILLEGAL;
                endcase
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_control   = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                state_next  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset silences the whole control word, including the debug state
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            alu_control   = ALU_AND;
            state_dbg     = '0;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.pc_source     = pc_source;
    assign bus.alu_control   = alu_control;
    assign bus.state         = state_dbg;
    assign bus.instr_done    = instr_done;
    assign bus.illegal_op    = illegal_op;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: a generator expands each instruction into its
// expected per-cycle control word trace; a driver replays the per-cycle inputs and
// a monitor pops and compares one expected word every cycle.
module tb_multicycle_ctrl_fsm;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_control;
        logic [3:0] state;
        logic       instr_done;
        logic       illegal_op;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       mem_ready;
    } stim_t;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    logic clk;
    logic rst;
    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    obs_t  exp_q[$];
    stim_t stim_q[$];
    obs_t  texp[$];
    stim_t tstim[$];
    logic [5:0] cur_op;
    logic [5:0] cur_fn;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic put(input obs_t o, input logic rdy);
        stim_t s;
        s.rst       = 1'b0;
        s.opcode    = cur_op;
        s.funct     = cur_fn;
        s.mem_ready = rdy;
        texp.push_back(o);
        tstim.push_back(s);
    endtask

    // A memory step: when memory can stall, the step repeats without its
    // completion side effects (IR/PC load, done) until mem_ready arrives.
    task automatic put_mem(input obs_t go);
`ifdef MEM_READY_EN
        obs_t hold;
        int   w;
        hold            = go;
        hold.pc_write   = 1'b0;
        hold.ir_write   = 1'b0;
        hold.instr_done = 1'b0;
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) put(hold, 1'b0);
        put(go, 1'b1);
`else
        put(go, 1'($urandom_range(0, 1)));
`endif
    endtask

    task automatic put_illegal();
        obs_t o;
        o = '0; o.illegal_op = 1'b1; o.state = 4'd12;
        put(o, 1'($urandom_range(0, 1)));
    endtask

    // Expected trace of one instruction; abort_k>0 asserts reset in cycle abort_k.
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_k);
        obs_t  o;
        stim_t s;
        logic [3:0] alu;
        bit ok;
        cur_op = op;
        cur_fn = fn;
        texp.delete();
        tstim.delete();

        o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        o.alu_src_b = 2'b01; o.alu_control = A_ADD; o.state = 4'd0;
        put_mem(o);
        o = '0; o.alu_src_b = 2'b11; o.alu_control = A_ADD; o.state = 4'd1;
        put(o, 1'($urandom_range(0, 1)));

        case (op)
            6'b100011, 6'b101011: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = A_ADD; o.state = 4'd2;
                put(o, 1'($urandom_range(0, 1)));
                if (op == 6'b100011) begin
                    o = '0; o.mem_read = 1'b1; o.i_or_d = 1'b1; o.state = 4'd3;
                    put_mem(o);
                    o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1; o.state = 4'd4;
                    put(o, 1'($urandom_range(0, 1)));
                end else begin
                    o = '0; o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = 1'b1; o.state = 4'd5;
                    put_mem(o);
                end
            end
            6'b000000: begin
                ok = 1'b1;
                case (fn)
                    6'b100100: alu = A_AND;
                    6'b100101: alu = A_OR;
                    6'b100000: alu = A_ADD;
                    6'b100010: alu = A_SUB;
                    6'b101010: alu = A_SLT;
                    default: begin alu = A_AND; ok = 1'b0; end
                endcase
                o = '0; o.alu_src_a = 1'b1; o.alu_control = alu; o.state = 4'd6;
                put(o, 1'($urandom_range(0, 1)));
                if (ok) begin
                    o = '0; o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1; o.state = 4'd7;
                    put(o, 1'($urandom_range(0, 1)));
                end else begin
                    put_illegal();
                end
            end
            6'b000100: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_control = A_SUB; o.pc_write_cond = 1'b1;
                o.pc_source = 2'b01; o.instr_done = 1'b1; o.state = 4'd8;
                put(o, 1'($urandom_range(0, 1)));
            end
            6'b000010: begin
                o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1; o.state = 4'd9;
                put(o, 1'($urandom_range(0, 1)));
            end
            6'b001000: begin
                o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = A_ADD; o.state = 4'd10;
                put(o, 1'($urandom_range(0, 1)));
                o = '0; o.reg_write = 1'b1; o.instr_done = 1'b1; o.state = 4'd11;
                put(o, 1'($urandom_range(0, 1)));
            end
            default: put_illegal();
        endcase

        if (abort_k > 0 && abort_k < texp.size()) begin
            while (texp.size() > abort_k) begin
                void'(texp.pop_back());
                void'(tstim.pop_back());
            end
            s.rst = 1'b1; s.opcode = op; s.funct = fn; s.mem_ready = 1'($urandom_range(0, 1));
            texp.push_back('0);
            tstim.push_back(s);
        end
        foreach (texp[i])  exp_q.push_back(texp[i]);
        foreach (tstim[i]) stim_q.push_back(tstim[i]);
    endtask

    task automatic gen_random();
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] valid_fn [5];
        int k;
        valid_fn[0] = 6'b100100; valid_fn[1] = 6'b100101; valid_fn[2] = 6'b100000;
        valid_fn[3] = 6'b100010; valid_fn[4] = 6'b101010;
        case ($urandom_range(0, 6))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = 6'b001000;
            default: op = 6'($urandom);
        endcase
        if ($urandom_range(0, 3) != 0) fn = valid_fn[$urandom_range(0, 4)];
        else                           fn = 6'($urandom);
        k = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
        gen_instr(op, fn, k);
    endtask

    // Monitor: one expected control word per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.pc_write      = bus.pc_write;
            a.pc_write_cond = bus.pc_write_cond;
            a.i_or_d        = bus.i_or_d;
            a.mem_read      = bus.mem_read;
            a.mem_write     = bus.mem_write;
            a.ir_write      = bus.ir_write;
            a.mem_to_reg    = bus.mem_to_reg;
            a.reg_dst       = bus.reg_dst;
            a.reg_write     = bus.reg_write;
            a.alu_src_a     = bus.alu_src_a;
            a.alu_src_b     = bus.alu_src_b;
            a.pc_source     = bus.pc_source;
            a.alu_control   = bus.alu_control;
            a.state         = bus.state;
            a.instr_done    = bus.instr_done;
            a.illegal_op    = bus.illegal_op;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL ctrl_word cycle %0d: got %06h (state %0d) expected %06h (state %0d)",
                         cyc, a, a.state, e, e.state);
            end
            cyc++;
        end
    end

    initial begin
        stim_t s;
        rst           = 1'b1;
        bus.opcode    = 6'b100011;
        bus.funct     = 6'b0;
        bus.mem_ready = 1'b0;

        // Two reset cycles with lw on the bus: control word must be all zero.
        for (int i = 0; i < 2; i++) begin
            s.rst = 1'b1; s.opcode = 6'b100011; s.funct = 6'b0; s.mem_ready = 1'b0;
            stim_q.push_back(s);
            exp_q.push_back('0);
        end
        gen_instr(6'b100011, 6'b000000, 0);
        gen_instr(6'b000000, 6'b100010, 0);
        gen_instr(6'b000100, 6'b000000, 0);
        gen_instr(6'b111111, 6'b000000, 0);
        gen_instr(6'b000000, 6'b000111, 0);
        gen_instr(6'b101011, 6'b000000, 0);
        gen_instr(6'b000010, 6'b000000, 0);
        gen_instr(6'b001000, 6'b000000, 0);
        gen_instr(6'b101011, 6'b000000, 4);
        gen_instr(6'b100011, 6'b000000, 2);
        for (int i = 0; i < 200; i++) gen_random();

        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            rst           = s.rst;
            bus.opcode    = s.opcode;
            bus.funct     = s.funct;
            bus.mem_ready = s.mem_ready;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL trace_drain: got %0d words left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
